sat_addsub_pipe: RTL and testbench
==================================

// Module: sat_addsub_pipe
// PURPOSE
//   Parametrised, pipelined signed add/subtract with selectable saturation.
//   Per-beat modes, valid/ready streaming handshake with backpressure, and a
//   sticky overflow-event counter. It is the streaming datapath arithmetic
//   primitive and feeds accumulators and filters downstream.
// PARAMETERS
//   WIDTH     16  operand/result width, two's complement (>=4)
//   STAGES    2   register stages from accept to output (1..4)
//   SYMMETRIC 1   1: negative clamp = -(2^(WIDTH-1)-1) (0x8001 @16b); 0: -2^(WIDTH-1)
//   CNT_W     8   width of overflow-event counter
// PORTS
//   clk        in   1        rising-edge clock
//   rst_n      in   1        async active-low reset
//   in_valid   in   1        input beat valid
//   in_ready   out  1        input accepted when in_valid && in_ready
//   in_a       in   WIDTH    signed operand A
//   in_b       in   WIDTH    signed operand B
//   in_sub     in   1        1: A-B, 0: A+B (per beat)
//   in_sat     in   1        1: saturate, 0: wrap (per beat)
//   out_valid  out  1        result beat valid
//   out_ready  in   1        downstream accept
//   out_sum    out  WIDTH    result
//   out_cout   out  1        unsigned carry out of bit WIDTH-1 (sub: 1 = no borrow)
//   out_ovf    out  1        1 when out_sum != exact mathematical result
//   ovf_cnt    out  CNT_W    count of accepted out_ovf beats, saturating
//   cnt_clr    in   1        sync clear of ovf_cnt
// BEHAVIOUR
//   Reset (async on rst_n low): all stage valids, out_valid, out_sum, out_cout,
//     out_ovf, ovf_cnt = 0. In-flight beats are discarded. in_ready = 1 after release.
//   Arithmetic: exact = sext(A) +/- sext(B) in WIDTH+1 bits. No early overflow
//     at -B for B = -2^(WIDTH-1).
//     MAX = 2^(WIDTH-1)-1; MIN = SYMMETRIC ? -MAX : -2^(WIDTH-1).
//     in_sat=1: clamp exact to [MIN, MAX].
//     in_sat=0: out_sum = exact[WIDTH-1:0].
//     out_ovf = (out_sum != exact). With SYMMETRIC=1, an exact -2^(WIDTH-1)
//     clamps to MIN and sets out_ovf.
//     out_cout = bit WIDTH of the unsigned sum A + (sub ? ~B : B) + sub.
//   Pipeline: STAGES stages in lockstep, fixed latency STAGES cycles.
//     A beat accepted at edge k shows out_valid at edge k+STAGES if no stall.
//     Stall = out_valid && !out_ready. On a stall all stages hold and in_ready=0.
//     in_ready = !stall (combinational from out_ready). Bubbles are not compressed.
//   Output regs are stable while out_valid && !out_ready (AXI-style). A beat
//     transfers when out_valid && out_ready. Order is always preserved.
//   Counter: +1 on each transfer with out_ovf=1, saturates at 2^CNT_W-1.
//     cnt_clr wins over a same-cycle increment (result 0).
//   No combinational path from in_* to out_*. Only in_ready depends on out_ready.
// TESTING (WIDTH=16, STAGES=2 unless noted; out_ready=1 unless noted)
//   1 sat: 0x7000+0x2000 -> 0x7FFF ovf=1 cout=0; same with sat=0 -> 0x9000
//     ovf=1; 0x1234+0x0001 -> 0x1235 ovf=0; each appears 2 cycles after accept.
//   2 neg clamp: 0xC000+0xC000 sat=1 -> SYMMETRIC=1: 0x8001 ovf=1;
//     SYMMETRIC=0: 0x8000 ovf=0 cout=1.
//   3 sub: 0x0000-0x8000 sat=1 -> 0x7FFF ovf=1; sat=0 -> 0x8000 ovf=1;
//     0x0005-0x0003 -> 0x0002 cout=1.
//   4 backpressure: 8 back-to-back beats, out_ready low cycles 3-5 ->
//     in_ready low same cycles, outputs held stable, all 8 delivered in order.
//   5 counter (CNT_W=3): 9 overflowing beats -> ovf_cnt 1..7 then holds 7;
//     cnt_clr coincident with an ovf transfer -> 0.
//   6 reset mid-stream: rst_n low with 2 beats in flight -> out_valid=0 at once;
//     after release no stale beat emerges; next beat has latency 2.

Source files
------------

// File: rtl/sat_addsub_pipe.sv
// Pipelined signed add/subtract with per-beat saturate/wrap select, valid/ready
// streaming with backpressure, and a saturating overflow-event counter.
module sat_addsub_pipe #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned STAGES    = 2,
  parameter int unsigned SYMMETRIC = 1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             cnt_clr
);

  localparam int unsigned W     = WIDTH;
  localparam int unsigned IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;

  // Clamp limits held sign-extended to W+1 bits so they compare directly with the exact result.
  localparam logic [W:0] MAX_EXT = {2'b00, {(W-1){1'b1}}};
  localparam logic [W:0] MIN_EXT = (SYMMETRIC != 0) ? {2'b11, {(W-2){1'b0}}, 1'b1}
                                                     : {2'b11, {(W-1){1'b0}}};

  logic             stall;
  logic [W-1:0]     b_op;
  logic [W:0]       exact;
  logic [W:0]       uns;
  logic [W-1:0]     res;
  logic             ovf_c;
  logic             cout_c;

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] cout_q;
  logic [STAGES-1:0] ovf_q;
  logic [W-1:0]      sum_q [STAGES];

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Subtraction as A + ~B + 1 keeps -B exact even for the most negative B.
  always_comb begin
    b_op   = in_sub ? ~in_b : in_b;
    exact  = {in_a[W-1], in_a} + {b_op[W-1], b_op} + (W+1)'(in_sub);
    uns    = {1'b0, in_a} + {1'b0, b_op} + (W+1)'(in_sub);
    res    = uns[W-1:0];
    cout_c = uns[W];
    if (in_sat) begin
      if ($signed(exact) > $signed(MAX_EXT)) begin
        res = MAX_EXT[W-1:0];
      end else if ($signed(exact) < $signed(MIN_EXT)) begin
        res = MIN_EXT[W-1:0];
      end
    end
    ovf_c = ({res[W-1], res} != exact);
  end

  // All stages advance together unless the output beat is stalled; bubbles travel too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      cout_q <= '0;
      ovf_q  <= '0;
      for (int i = 0; i < int'(STAGES); i++) begin
        sum_q[IDX_W'(i)] <= '0;
      end
    end else if (!stall) begin
      vld_q[0] <= in_valid;
      if (in_valid) begin
        sum_q[0]  <= res;
        cout_q[0] <= cout_c;
        ovf_q[0]  <= ovf_c;
      end
      for (int i = 1; i < int'(STAGES); i++) begin
        vld_q[IDX_W'(i)]  <= vld_q[IDX_W'(i-1)];
        sum_q[IDX_W'(i)]  <= sum_q[IDX_W'(i-1)];
        cout_q[IDX_W'(i)] <= cout_q[IDX_W'(i-1)];
        ovf_q[IDX_W'(i)]  <= ovf_q[IDX_W'(i-1)];
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_sum   = sum_q[STAGES-1];
  assign out_cout  = cout_q[STAGES-1];
  assign out_ovf   = ovf_q[STAGES-1];

  // Overflow events are counted on transfer; a clear in the same cycle takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (cnt_clr) begin
      ovf_cnt <= '0;
    end else if (out_valid && out_ready && out_ovf && (ovf_cnt != '1)) begin
      ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sat_addsub_pipe.sv
// Scoreboard bench for sat_addsub_pipe: a symmetric-clamp instance (3-bit counter)
// and an asymmetric instance share stimulus; a negedge monitor checks every output beat.
module tb_sat_addsub_pipe;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        sat;
    logic [15:0] s_sum;
    logic        s_ovf;
    logic [15:0] x_sum;
    logic        x_ovf;
    logic        cout;
  } vec_t;

  typedef struct {
    logic [15:0] s_sum;
    logic        s_ovf;
    logic [15:0] x_sum;
    logic        x_ovf;
    logic        cout;
    bit          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_sub, in_sat, out_ready, cnt_clr;
  logic [15:0] in_a, in_b;
  logic        in_ready_s, out_valid_s, out_cout_s, out_ovf_s;
  logic [15:0] out_sum_s;
  logic [2:0]  ovf_cnt_s;
  logic        in_ready_x, out_valid_x, out_cout_x, out_ovf_x;
  logic [15:0] out_sum_x;
  logic [7:0]  ovf_cnt_x;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   popped = 0;
  int   rdy_low = 0;
  bit   bp_phase = 0;
  bit   inc_pend = 0;
  bit   prev_stall = 0;
  logic [15:0] prev_sum;
  logic [1:0]  prev_flags;
  logic [2:0]  cnt_m;
  exp_t sb[$];
  exp_t me;

  vec_t vecs [12] = '{
    '{16'h7000, 16'h2000, 1'b0, 1'b1, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1, 1'b0},
    '{16'h7000, 16'h2000, 1'b0, 1'b0, 16'h9000, 1'b1, 16'h9000, 1'b1, 1'b0},
    '{16'h1234, 16'h0001, 1'b0, 1'b1, 16'h1235, 1'b0, 16'h1235, 1'b0, 1'b0},
    '{16'hC000, 16'hC000, 1'b0, 1'b1, 16'h8001, 1'b1, 16'h8000, 1'b0, 1'b1},
    '{16'h0000, 16'h8000, 1'b1, 1'b1, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1, 1'b0},
    '{16'h0000, 16'h8000, 1'b1, 1'b0, 16'h8000, 1'b1, 16'h8000, 1'b1, 1'b0},
    '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b0, 16'h0002, 1'b0, 1'b1},
    '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8001, 1'b1, 16'h8000, 1'b1, 1'b1},
    '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1},
    '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8001, 1'b1, 16'h8000, 1'b1, 1'b1},
    '{16'h7FFF, 16'hFFFF, 1'b1, 1'b0, 16'h8000, 1'b1, 16'h8000, 1'b1, 1'b0},
    '{16'h8000, 16'h0000, 1'b0, 1'b1, 16'h8001, 1'b1, 16'h8000, 1'b0, 1'b0}
  };

  sat_addsub_pipe #(.WIDTH(16), .STAGES(2), .SYMMETRIC(1), .CNT_W(3)) u_sym (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_sat(in_sat),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_sum(out_sum_s),
    .out_cout(out_cout_s), .out_ovf(out_ovf_s), .ovf_cnt(ovf_cnt_s), .cnt_clr(cnt_clr)
  );

  sat_addsub_pipe #(.WIDTH(16), .STAGES(2), .SYMMETRIC(0), .CNT_W(8)) u_asym (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_x),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_sat(in_sat),
    .out_valid(out_valid_x), .out_ready(out_ready), .out_sum(out_sum_x),
    .out_cout(out_cout_x), .out_ovf(out_ovf_x), .ovf_cnt(ovf_cnt_x), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  function automatic exp_t mk(input vec_t v, input bit lat);
    exp_t e;
    e.s_sum = v.s_sum; e.s_ovf = v.s_ovf;
    e.x_sum = v.x_sum; e.x_ovf = v.x_ovf;
    e.cout  = v.cout;  e.lat   = lat; e.acc = 0;
    return e;
  endfunction

  // Entered just after a rising edge; returns just after the edge that captured the beat.
  task automatic send(input vec_t v, input bit lat, input bit push);
    int   tries = 0;
    bit   done = 0;
    exp_t e = mk(v, lat);
    in_valid = 1'b1; in_a = v.a; in_b = v.b; in_sub = v.sub; in_sat = v.sat;
    while (!done) begin
      @(negedge clk);
      if (in_ready_s) begin
        e.acc = cyc;
        if (push) sb.push_back(e);
        done = 1;
      end else if (++tries > 50) begin
        fail_now("send_timeout");
        done = 1;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid_s) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) fail_now("drain_timeout");
  endtask

  // Reference overflow counter for the 3-bit instance, driven by scoreboard expectations.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_m <= 3'd0;
    else if (cnt_clr) cnt_m <= 3'd0;
    else if (inc_pend && cnt_m != 3'd7) cnt_m <= cnt_m + 3'd1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
      inc_pend = 0;
    end else begin
      inc_pend = 0;
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid_s), 32'd1);
        chk("hold_sum", 32'(out_sum_s), 32'(prev_sum));
        chk("hold_flags", 32'({out_cout_s, out_ovf_s}), 32'(prev_flags));
      end
      if (out_valid_s && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 32'(out_valid_s), 32'd0);
        end else begin
          me = sb.pop_front();
          popped++;
          chk("sum", 32'(out_sum_s), 32'(me.s_sum));
          chk("ovf", 32'(out_ovf_s), 32'(me.s_ovf));
          chk("cout", 32'(out_cout_s), 32'(me.cout));
          chk("x_valid", 32'(out_valid_x), 32'd1);
          chk("x_sum", 32'(out_sum_x), 32'(me.x_sum));
          chk("x_ovf", 32'(out_ovf_x), 32'(me.x_ovf));
          chk("x_cout", 32'(out_cout_x), 32'(me.cout));
          chk("ovf_cnt", 32'(ovf_cnt_s), 32'(cnt_m));
          if (me.lat) chk("latency", 32'(cyc - me.acc), 32'd2);
          inc_pend = me.s_ovf;
        end
      end
      if (bp_phase) begin
        chk("in_ready", 32'(in_ready_s), 32'(!(out_valid_s && !out_ready)));
        chk("x_in_ready", 32'(in_ready_x), 32'(in_ready_s));
        if (!in_ready_s) rdy_low++;
      end
      prev_stall = out_valid_s && !out_ready;
      prev_sum   = out_sum_s;
      prev_flags = {out_cout_s, out_ovf_s};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   base;
    int   seen;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_sat = 1'b0;
    out_ready = 1'b1; cnt_clr = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid_s), 32'd0);
    chk("rst_out_sum", 32'(out_sum_s), 32'd0);
    chk("rst_flags", 32'({out_cout_s, out_ovf_s}), 32'd0);
    chk("rst_ovf_cnt", 32'(ovf_cnt_s), 32'd0);
    chk("rst_x_ovf_cnt", 32'(ovf_cnt_x), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready_s), 32'd1);

    // Directed arithmetic vectors, back to back
    for (int i = 0; i < 12; i++) send(vecs[i], 1'b1, 1'b1);
    in_valid = 1'b0;
    drain();

    // Backpressure: ready low for cycles 3..5 of an 8-beat burst
    base = popped; rdy_low = 0; bp_phase = 1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          v = '{16'(i * 256), 16'h0011, 1'b0, 1'b1, 16'(i * 256 + 17), 1'b0,
                16'(i * 256 + 17), 1'b0, 1'b0};
          send(v, 1'b0, 1'b1);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    bp_phase = 0;
    chk("bp_delivered", 32'(popped - base), 32'd8);
    chk("bp_ready_low_cycles", 32'(rdy_low), 32'd3);

    // Counter: clear, then nine overflowing beats saturate the 3-bit count
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    for (int i = 0; i < 9; i++) send(vecs[0], 1'b1, 1'b1);
    in_valid = 1'b0;
    drain();
    chk("cnt_saturated", 32'(ovf_cnt_s), 32'd7);

    // Clear coincident with an overflowing transfer
    out_ready = 1'b0;
    send(vecs[0], 1'b0, 1'b1);
    in_valid = 1'b0;
    seen = 0;
    while (!out_valid_s && seen < 10) begin
      @(posedge clk); #1;
      seen++;
    end
    if (seen >= 10) fail_now("clr_wait");
    cnt_clr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("cnt_clr_wins", 32'(ovf_cnt_s), 32'd0);
    chk("x_cnt_clr_wins", 32'(ovf_cnt_x), 32'd0);
    @(posedge clk); #1;
    drain();

    // Reset with two beats in flight
    v = '{16'h1111, 16'h1111, 1'b0, 1'b0, 16'h2222, 1'b0, 16'h2222, 1'b0, 1'b0};
    send(v, 1'b0, 1'b0);
    send(v, 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("inflight_valid", 32'(out_valid_s), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid_s), 32'd0);
    chk("rst_mid_x_valid", 32'(out_valid_x), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid_s || out_valid_x) seen++;
    end
    chk("stale_beats", 32'(seen), 32'd0);
    @(posedge clk); #1;
    v = '{16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0, 16'h0300, 1'b0, 1'b0};
    send(v, 1'b1, 1'b1);
    in_valid = 1'b0;
    drain();
    chk("post_rst_cnt", 32'(ovf_cnt_s), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
